// File: rtl/dup_pair_finder_pkg.sv
// Shared definitions for the redundancy-controller front end: default sizing,
// the controller state encoding, and small constant helpers. The distance
// calculation stage imports the same package so both stages agree on widths.
package dup_pair_finder_pkg;

    // Default weight word width (also the index width).
    localparam int DEF_WORD_WIDTH = 8;

    // Default kernel buffer depth in elements.
    localparam int DEF_MAX_ELEM = 16;

    // Controller state encoding, kept as plain 3-bit constants so older
    // consumers of this package can compare against them directly.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_SCAN = 3'd2;
    localparam logic [2:0] ST_EMIT = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // A kernel length is usable only if it is non-empty and fits the buffer.
    function automatic logic count_is_legal(input int n, input int max_elem);
        return (n != 0) && (n <= max_elem);
    endfunction

    // Address width of a buffer with the given depth (at least one bit).
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dup_pair_finder_kernel_elem_buf.sv
// Kernel element buffer: a small register file holding one lowered kernel.
// One synchronous write port used while loading, two combinational read
// ports used by the scanner to look at buf[i] and buf[j] in the same cycle.
module kernel_elem_buf #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [WIDTH-1:0]  o_rdata_a,
    output logic [WIDTH-1:0]  o_rdata_b
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write one element per enabled cycle.
    // NOTE: storage has no reset; every entry the scanner reads is written during LOAD first, so clearing it would only cost reset fan-out.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/dup_pair_finder.sv
// Duplicate pair finder: loads one kernel serially, then for every non-zero
// element j searches backwards for the nearest earlier element i of equal
// value and hands the pair (i, j) downstream over a valid/ready handshake.
module dup_pair_finder
    import dup_pair_finder_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int MAX_ELEM   = DEF_MAX_ELEM
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [WORD_WIDTH-1:0] i_elem_count,
    input  logic                  i_wr_en,
    input  logic [WORD_WIDTH-1:0] i_wr_data,
    output logic                  o_pair_valid,
    input  logic                  i_pair_ready,
    output logic [WORD_WIDTH-1:0] o_idx1,
    output logic [WORD_WIDTH-1:0] o_idx2,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [WORD_WIDTH-1:0] o_pair_count,
    output logic                  o_exception
);

    localparam int                    ADDR_W = addr_width(MAX_ELEM);
    localparam logic [WORD_WIDTH-1:0] ONE    = WORD_WIDTH'(1);

    // Controller state and pointers.
    logic [2:0]            r_state;
    logic [WORD_WIDTH-1:0] r_last;        // index of the last element (N-1)
    logic [WORD_WIDTH-1:0] r_ptr;         // load pointer
    logic [WORD_WIDTH-1:0] r_j;           // element being resolved
    logic [WORD_WIDTH-1:0] r_i;           // candidate earlier element
    logic [WORD_WIDTH-1:0] r_idx1;
    logic [WORD_WIDTH-1:0] r_idx2;
    logic [WORD_WIDTH-1:0] r_pair_count;
    logic                  r_pair_valid;
    logic                  r_exception;

    // Buffer read data and scan decisions.
    logic [WORD_WIDTH-1:0] w_elem_i;
    logic [WORD_WIDTH-1:0] w_elem_j;
    logic                  w_buf_we;
    logic                  w_start_ok;
    logic                  w_j_zero;
    logic                  w_match;
    logic                  w_j_is_last;
    logic [2:0]            w_adv_state;
    logic [WORD_WIDTH-1:0] w_next_j;

    assign w_buf_we    = (r_state == ST_LOAD) && i_wr_en;
    assign w_start_ok  = count_is_legal(32'(i_elem_count), MAX_ELEM);

    // A zero element is never paired, so it is skipped without a compare;
    // because buf[j] is non-zero whenever a compare happens, a zero buf[i]
    // can never match either.
    assign w_j_zero    = (w_elem_j == '0);
    assign w_match     = (w_elem_i == w_elem_j);

    // Resolving j either moves on to j+1 (searching from i = old j) or,
    // after the last element, finishes the kernel.
    assign w_j_is_last = (r_j == r_last);
    assign w_adv_state = w_j_is_last ? ST_DONE : ST_SCAN;
    assign w_next_j    = r_j + ONE;

    kernel_elem_buf #(
        .DEPTH  (MAX_ELEM),
        .WIDTH  (WORD_WIDTH),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .i_clk     (i_clk),
        .i_we      (w_buf_we),
        .i_waddr   (r_ptr[ADDR_W-1:0]),
        .i_wdata   (i_wr_data),
        .i_raddr_a (r_i[ADDR_W-1:0]),
        .i_raddr_b (r_j[ADDR_W-1:0]),
        .o_rdata_a (w_elem_i),
        .o_rdata_b (w_elem_j)
    );

    // Controller: load, scan one compare per cycle, hold pairs until accepted.
    // NOTE: every register here uses <= so all state updates see the values from before the clock edge, regardless of statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_last       <= '0;
            r_ptr        <= '0;
            r_j          <= '0;
            r_i          <= '0;
            r_idx1       <= '0;
            r_idx2       <= '0;
            r_pair_count <= '0;
            r_pair_valid <= 1'b0;
            r_exception  <= 1'b0;
        end else begin
            r_exception <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (w_start_ok) begin
                            r_state      <= ST_LOAD;
                            r_last       <= i_elem_count - ONE;
                            r_ptr        <= '0;
                            r_pair_count <= '0;
                        end else begin
                            r_exception  <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    if (i_wr_en) begin
                        r_ptr <= r_ptr + ONE;
                        if (r_ptr == r_last) begin
                            // A single-element kernel has nothing to pair.
                            if (r_last == '0) begin
                                r_state <= ST_DONE;
                            end else begin
                                r_state <= ST_SCAN;
                                r_j     <= ONE;
                                r_i     <= '0;
                            end
                        end
                    end
                end

                ST_SCAN: begin
                    if (w_j_zero || (!w_match && r_i == '0)) begin
                        r_state <= w_adv_state;
                        r_j     <= w_next_j;
                        r_i     <= r_j;
                    end else if (w_match) begin
                        r_state      <= ST_EMIT;
                        r_pair_valid <= 1'b1;
                        r_idx1       <= r_i;
                        r_idx2       <= r_j;
                    end else begin
                        r_i <= r_i - ONE;
                    end
                end

                ST_EMIT: begin
                    // idx1/idx2 stay untouched until the transfer happens.
                    if (i_pair_ready) begin
                        r_pair_valid <= 1'b0;
                        r_pair_count <= r_pair_count + ONE;
                        r_state      <= w_adv_state;
                        r_j          <= w_next_j;
                        r_i          <= r_j;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status outputs decoded from the registered state.
    // NOTE: both outputs get a default before the case so no path leaves them unassigned, which would infer a latch.
    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            ST_LOAD, ST_SCAN, ST_EMIT: o_busy = 1'b1;
            ST_DONE:                   o_done = 1'b1;
            default:                   ;
        endcase
    end

    assign o_pair_valid = r_pair_valid;
    assign o_idx1       = r_idx1;
    assign o_idx2       = r_idx2;
    assign o_pair_count = r_pair_count;
    assign o_exception  = r_exception;

endmodule

// File: doc/dup_pair_finder.md
# dup_pair_finder

Upstream stage of the redundancy-controller datapath. Buffers one serially loaded kernel (up to MAX_ELEM lowered weight elements), then scans it and, for every non-zero element, emits the index pair (idx1, idx2) linking it to its nearest preceding element of equal value. Pairs leave over a valid/ready handshake and feed the distance-calculation stage, which turns each index pair into a LIFM element distance.

## Interface
- WORD_WIDTH, 8: weight word width and index width.
- MAX_ELEM, 16: kernel buffer depth (elements); requires MAX_ELEM ≤ 2^WORD_WIDTH.

Ports:
- clk  in  1  clock, positive edge.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  begin new kernel; sampled only in IDLE.
- elem_count  in  WORD_WIDTH  number of kernel elements N, captured on accepted start.
- wr_en  in  1  load strobe, one element per cycle.
- wr_data  in  WORD_WIDTH  kernel element value.
- pair_valid  out  1  idx1/idx2 hold a valid pair.
- pair_ready  in  1  downstream accepts pair.
- idx1  out  WORD_WIDTH  earlier index i.
- idx2  out  WORD_WIDTH  later index j (i < j).
- busy  out  1  high in LOAD, SCAN, EMIT.
- done  out  1  one-cycle pulse at end of scan.
- pair_count  out  WORD_WIDTH  pairs emitted for the current kernel.
- exception  out  1  one-cycle pulse on illegal elem_count.

## Operation
- States: IDLE, LOAD, SCAN, EMIT, DONE.
- IDLE: start with 1 ≤ elem_count ≤ MAX_ELEM → LOAD; pair_count and load pointer cleared. start with elem_count 0 or > MAX_ELEM → exception pulse, remain IDLE.
- LOAD: each wr_en cycle writes wr_data to buf[ptr] and increments ptr. After the Nth write → SCAN with j=1, i=0. If N = 1, go directly → DONE.
- SCAN: one comparison per cycle.
  - If buf[j] == 0, skip j immediately (1 cycle, no compare).
  - Otherwise compare buf[i] with buf[j], i stepping from j-1 down to 0.
  - On match → EMIT with idx1=i, idx2=j.
  - If no match at i=0 → advance j.
- Advancing j: j=j+1, i=j_old. If j_old == N-1 → DONE.
- Zero elements are never paired, as either i or j.
- EMIT: pair_valid=1. On pair_valid && pair_ready: pair_count++, then advance j as above.
- DONE: done=1 for one cycle → IDLE. pair_count holds until the next accepted start.
- start is ignored outside IDLE. wr_en is ignored outside LOAD.

## Timing
- Reset values: pair_valid 0, idx1 0, idx2 0, busy 0, done 0, pair_count 0, exception 0, state IDLE. Buffer contents undefined after reset.
- Accepted start → busy=1 next cycle.
- Nth write in cycle t → first compare in cycle t+1.
- Match found in cycle t → pair_valid=1 from cycle t+1.
- idx1/idx2 are registered and stable while pair_valid && !pair_ready.
- pair_valid drops the cycle after the transfer (no back-to-back pairs).
- Element j costs at most j compare cycles plus the EMIT cycles; a zero element costs 1 cycle.
- done is asserted the cycle after the last j is resolved; busy=0 in the DONE cycle.
- pair_ready may be high with pair_valid low; it has no effect.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous); the pending pair is dropped.
- Index arithmetic is unsigned WORD_WIDTH. Worst-case pair_count is N-1, so it cannot overflow.

## Structure
- Shared package: state encoding localparams (IDLE..DONE, 3 bits) and the default WORD_WIDTH/MAX_ELEM constants, shared with the distance-calculation stage.
- Sub-module kernel_elem_buf: MAX_ELEM×WORD_WIDTH register file.
  - One synchronous write port.
  - Two combinational read ports (i, j).
  - No reset on storage.
- The FSM, pointers, counter and output registers live in dup_pair_finder.

## Test plan
- N=4, data 3,5,3,3, pair_ready=1 → pairs (0,2) then (2,3); pair_count=2; one done pulse; busy low afterwards.
- N=3, data 0,0,7 → no pair_valid; done pulse; pair_count=0.
- elem_count=0, then elem_count=17 (MAX_ELEM=16) → one exception pulse each; busy stays 0; wr_en ignored.
- N=2, data 9,9, pair_ready low for 5 cycles after pair_valid rises → idx1=0, idx2=1 held stable for 5 cycles; transfer on the 6th; pair_count=1; then done.
- Reset pulsed during SCAN of N=4 → all outputs 0; a new start with N=1 yields done with pair_count=0 and no pair_valid.
- start pulsed during LOAD, and wr_en during SCAN → no effect on the result of scenario 1.
